// File: rtl/audio_clk_pkg.sv
// ---------------------------------------------------------------------------
// audio_clk_pkg
// Shared definitions for the audio clock configuration sequencer:
//   - sequencer state encoding
//   - bit positions of the four divisor fields inside cmd_reg1/cmd_reg2
//     (the field layout is defined by the clock generator; the sequencer
//     only passes the words through)
//   - power-on default configuration words
// ---------------------------------------------------------------------------
package audio_clk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_LOAD    = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_RELEASE = 3'd4
   } seq_state_e;

   // Divisor field positions (cmd1: mclk/bclk, cmd2: lrclk1/lrclk2)
   localparam int MCLK_MSB   = 31;
   localparam int MCLK_LSB   = 24;
   localparam int BCLK_MSB   = 23;
   localparam int BCLK_LSB   = 16;
   localparam int LRCLK1_MSB = 15;
   localparam int LRCLK1_LSB = 8;
   localparam int LRCLK2_MSB = 7;
   localparam int LRCLK2_LSB = 0;

   // Power-on configuration words
   localparam logic [31:0] RESET_CMD1_DEFAULT = 32'h0301_0000;
   localparam logic [31:0] RESET_CMD2_DEFAULT = 32'h0000_0F0F;

endpackage

// File: rtl/audio_clk_cfg_sequencer_if.sv
// ---------------------------------------------------------------------------
// audio_clk_cfg_sequencer_if
// Requester-side bundle of the audio clock configuration sequencer.
//   req_valid[1:0]  per-requester request, held with data until ready
//   req_ready[1:0]  one-hot acceptance (transfer when valid & ready)
//   req0_cmd1/2     requester 0 (host bridge) configuration words
//   req1_cmd1/2     requester 1 (synth engine) configuration words
//   done[1:0]       one-cycle completion pulse to the granted requester
// master: requester side, slave: sequencer side.
// ---------------------------------------------------------------------------
interface audio_clk_cfg_sequencer_if;

   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req0_cmd1;
   logic [31:0] req0_cmd2;
   logic [31:0] req1_cmd1;
   logic [31:0] req1_cmd2;
   logic [1:0]  done;

   modport master (
      output req_valid,
      output req0_cmd1,
      output req0_cmd2,
      output req1_cmd1,
      output req1_cmd2,
      input  req_ready,
      input  done
   );

   modport slave (
      input  req_valid,
      input  req0_cmd1,
      input  req0_cmd2,
      input  req1_cmd1,
      input  req1_cmd2,
      output req_ready,
      output done
   );

endinterface

// File: rtl/audio_clk_rr_arbiter.sv
// ---------------------------------------------------------------------------
// audio_clk_rr_arbiter
// Two-way round-robin arbiter.
//   clk, reset_n  clock and synchronous active-low reset
//   req[1:0]      request vector
//   enable        grants are only issued while enable is high
//   advance       a grant was consumed; remember who won
//   gnt[1:0]      one-hot grant (combinational)
//   gnt_id        index of the granted requester
// After reset the last-grant pointer is 1, so requester 0 wins a tie first.
// ---------------------------------------------------------------------------
module audio_clk_rr_arbiter (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       enable,
   input  logic       advance,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   logic last_r;

   // Last-grant pointer, moves only when a grant is consumed
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_r <= 1'b1;
      end else if (advance) begin
         last_r <= gnt_id;
      end else begin
         last_r <= last_r;
      end
   end

   // Grant selection: a lone requester wins, a tie goes to the one not served last
   always_comb begin
      gnt = 2'b00;
      if (enable) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_r ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end else begin
         gnt = 2'b00;
      end
      gnt_id = gnt[1];
   end

endmodule

// File: rtl/audio_clk_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// audio_clk_cfg_sequencer
// Owns the clock generator configuration words and lrclk_clear. Two
// requesters are arbitrated round-robin; each accepted change mutes the LR
// clocks, loads the new words, waits for MCLK/BCLK to settle, then releases
// and pulses done to the requester. A request for the words already in
// place while locked completes immediately without muting.
//   clk_clkin     clock
//   reset_n       synchronous active-low reset (restarts the power-on settle)
//   req_if        requester bundle (slave modport)
//   cmd_reg1/2    configuration words to the clock generator
//   lrclk_clear   holds the LR dividers in reset
//   busy          sequencer not in IDLE
//   locked        clocks stable at the current configuration
// ---------------------------------------------------------------------------
module audio_clk_cfg_sequencer
   import audio_clk_pkg::*;
#(
   parameter int          CLEAR_CYCLES  = 16,
   parameter int          SETTLE_CYCLES = 256,
   parameter logic [31:0] RESET_CMD1    = RESET_CMD1_DEFAULT,
   parameter logic [31:0] RESET_CMD2    = RESET_CMD2_DEFAULT
) (
   input  logic                        clk_clkin,
   input  logic                        reset_n,
   audio_clk_cfg_sequencer_if.slave    req_if,
   output logic [31:0]                 cmd_reg1,
   output logic [31:0]                 cmd_reg2,
   output logic                        lrclk_clear,
   output logic                        busy,
   output logic                        locked
);

   localparam int MAX_CYCLES = (CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   seq_state_e       state_r;
   seq_state_e       state_s;
   logic [CNT_W-1:0] count_r;

   logic [31:0] stage_cmd1_r;
   logic [31:0] stage_cmd2_r;
   logic        stage_id_r;
   logic        stage_valid_r;

   logic [31:0] cmd_reg1_r;
   logic [31:0] cmd_reg2_r;
   logic        lrclk_clear_r;
   logic        busy_r;
   logic        locked_r;
   logic [1:0]  done_r;
   logic [1:0]  done_s;

   logic [1:0]  gnt_s;
   logic        gnt_id_s;
   logic        xfer_s;
   logic [31:0] sel_cmd1_s;
   logic [31:0] sel_cmd2_s;
   logic        skip_s;

   audio_clk_rr_arbiter u_arb (
      .clk     (clk_clkin),
      .reset_n (reset_n),
      .req     (req_if.req_valid),
      .enable  (state_r == ST_IDLE),
      .advance (xfer_s),
      .gnt     (gnt_s),
      .gnt_id  (gnt_id_s)
   );

   assign req_if.req_ready = gnt_s;
   assign req_if.done      = done_r;
   assign cmd_reg1         = cmd_reg1_r;
   assign cmd_reg2         = cmd_reg2_r;
   assign lrclk_clear      = lrclk_clear_r;
   assign busy             = busy_r;
   assign locked           = locked_r;

   assign xfer_s     = |(req_if.req_valid & gnt_s);
   assign sel_cmd1_s = gnt_id_s ? req_if.req1_cmd1 : req_if.req0_cmd1;
   assign sel_cmd2_s = gnt_id_s ? req_if.req1_cmd2 : req_if.req0_cmd2;
   // Same words while already locked: nothing to retune, finish at once
   assign skip_s     = (sel_cmd1_s == cmd_reg1_r) && (sel_cmd2_s == cmd_reg2_r) && locked_r;

   // Next-state and completion-pulse decode
   always_comb begin
      state_s = state_r;
      done_s  = 2'b00;
      case (state_r)
         ST_IDLE: begin
            if (xfer_s) begin
               state_s = skip_s ? ST_RELEASE : ST_CLEAR;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (count_r == CLEAR_LAST) begin
               state_s = ST_LOAD;
            end else begin
               state_s = ST_CLEAR;
            end
         end
         ST_LOAD:    state_s = ST_SETTLE;
         ST_SETTLE: begin
            if (count_r == SETTLE_LAST) begin
               state_s = ST_RELEASE;
            end else begin
               state_s = ST_SETTLE;
            end
         end
         ST_RELEASE: state_s = ST_IDLE;
         default:    state_s = ST_IDLE;
      endcase

      // The power-on settle has no staged request, so it raises no done
      if (state_s == ST_RELEASE) begin
         if (state_r == ST_IDLE) begin
            done_s[gnt_id_s] = 1'b1;
         end else if (stage_valid_r) begin
            done_s[stage_id_r] = 1'b1;
         end else begin
            done_s = 2'b00;
         end
      end else begin
         done_s = 2'b00;
      end
   end

   // State register and per-state cycle counter (cleared on every state entry)
   always_ff @(posedge clk_clkin) begin
      if (!reset_n) begin
         state_r <= ST_SETTLE;
         count_r <= '0;
      end else begin
         state_r <= state_s;
         if (state_s != state_r) begin
            count_r <= '0;
         end else if (state_r == ST_IDLE) begin
            count_r <= count_r;
         end else begin
            count_r <= count_r + CNT_W'(1);
         end
      end
   end

   // Request staging: words are captured only at the handshake
   always_ff @(posedge clk_clkin) begin
      if (!reset_n) begin
         stage_cmd1_r  <= 32'h0000_0000;
         stage_cmd2_r  <= 32'h0000_0000;
         stage_id_r    <= 1'b0;
         stage_valid_r <= 1'b0;
      end else if (xfer_s) begin
         stage_cmd1_r  <= sel_cmd1_s;
         stage_cmd2_r  <= sel_cmd2_s;
         stage_id_r    <= gnt_id_s;
         stage_valid_r <= 1'b1;
      end else if (state_r == ST_RELEASE) begin
         stage_valid_r <= 1'b0;
      end else begin
         stage_valid_r <= stage_valid_r;
      end
   end

   // Configuration words: updated only from the LOAD state
   always_ff @(posedge clk_clkin) begin
      if (!reset_n) begin
         cmd_reg1_r <= RESET_CMD1;
         cmd_reg2_r <= RESET_CMD2;
      end else if (state_r == ST_LOAD) begin
         cmd_reg1_r <= stage_cmd1_r;
         cmd_reg2_r <= stage_cmd2_r;
      end else begin
         cmd_reg1_r <= cmd_reg1_r;
         cmd_reg2_r <= cmd_reg2_r;
      end
   end

   // Status outputs registered from the next state so they align with state_r
   always_ff @(posedge clk_clkin) begin
      if (!reset_n) begin
         lrclk_clear_r <= 1'b1;
         busy_r        <= 1'b1;
         locked_r      <= 1'b0;
         done_r        <= 2'b00;
      end else begin
         lrclk_clear_r <= (state_s == ST_CLEAR) || (state_s == ST_LOAD) || (state_s == ST_SETTLE);
         busy_r        <= (state_s != ST_IDLE);
         done_r        <= done_s;
         if (state_s == ST_RELEASE) begin
            locked_r <= 1'b1;
         end else if (state_s == ST_CLEAR) begin
            locked_r <= 1'b0;
         end else begin
            locked_r <= locked_r;
         end
      end
   end

endmodule

// File: tb/tb_audio_clk_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_audio_clk_cfg_sequencer
// Directed testbench for audio_clk_cfg_sequencer with CLEAR_CYCLES=4,
// SETTLE_CYCLES=8. Handshake at cycle T: CLEAR T+1..T+4, LOAD T+5,
// new words visible T+6, SETTLE T+6..T+13, RELEASE/done T+14.
// ---------------------------------------------------------------------------
module tb_audio_clk_cfg_sequencer;

   localparam int CLR = 4;
   localparam int SET = 8;
   localparam logic [31:0] RST1 = 32'h0301_0000;
   localparam logic [31:0] RST2 = 32'h0000_0F0F;

   logic        clk_clkin = 1'b0;
   logic        reset_n;
   logic [31:0] cmd_reg1;
   logic [31:0] cmd_reg2;
   logic        lrclk_clear;
   logic        busy;
   logic        locked;

   int checks = 0;
   int errors = 0;

   audio_clk_cfg_sequencer_if req_if ();

   audio_clk_cfg_sequencer #(
      .CLEAR_CYCLES  (CLR),
      .SETTLE_CYCLES (SET),
      .RESET_CMD1    (RST1),
      .RESET_CMD2    (RST2)
   ) u_dut (
      .clk_clkin   (clk_clkin),
      .reset_n     (reset_n),
      .req_if      (req_if),
      .cmd_reg1    (cmd_reg1),
      .cmd_reg2    (cmd_reg2),
      .lrclk_clear (lrclk_clear),
      .busy        (busy),
      .locked      (locked)
   );

   always #5 clk_clkin = ~clk_clkin;

   task automatic step();
      @(posedge clk_clkin);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req_if.req_valid = 2'b00;
      req_if.req0_cmd1 = 32'h0; req_if.req0_cmd2 = 32'h0;
      req_if.req1_cmd1 = 32'h0; req_if.req1_cmd2 = 32'h0;
      step(); step();
      checks++; if (cmd_reg1 !== RST1) begin errors++; $display("FAIL rst_cmd1: got %h expected %h", cmd_reg1, RST1); end
      checks++; if (cmd_reg2 !== RST2) begin errors++; $display("FAIL rst_cmd2: got %h expected %h", cmd_reg2, RST2); end
      checks++; if ({lrclk_clear, busy, locked} !== 3'b110) begin errors++; $display("FAIL rst_status: got clr/busy/lock %b expected 110", {lrclk_clear, busy, locked}); end
      checks++; if ({req_if.req_ready, req_if.done} !== 4'b0000) begin errors++; $display("FAIL rst_ready_done: got %b expected 0000", {req_if.req_ready, req_if.done}); end
      reset_n = 1'b1;
      for (int i = 0; i < SET; i++) begin
         checks++; if (lrclk_clear !== 1'b1 || req_if.done !== 2'b00) begin errors++; $display("FAIL por_settle[%0d]: got clr %b done %b expected 1 00", i, lrclk_clear, req_if.done); end
         step();
      end
      checks++; if ({lrclk_clear, locked, req_if.done} !== 4'b0100) begin errors++; $display("FAIL por_release: got clr/lock/done %b expected 0100", {lrclk_clear, locked, req_if.done}); end
      step();
      checks++; if ({busy, lrclk_clear, locked} !== 3'b001) begin errors++; $display("FAIL por_idle: got busy/clr/lock %b expected 001", {busy, lrclk_clear, locked}); end
   endtask

   task automatic test_full_path();
      logic [31:0] exp1;
      req_if.req0_cmd1 = 32'h0101_0000;
      req_if.req0_cmd2 = 32'h0000_0707;
      req_if.req_valid = 2'b01;
      #1;
      checks++; if (req_if.req_ready !== 2'b01) begin errors++; $display("FAIL full_ready: got %b expected 01", req_if.req_ready); end
      step();
      req_if.req_valid = 2'b00;
      for (int k = 1; k <= CLR + 1 + SET; k++) begin
         exp1 = (k >= CLR + 2) ? 32'h0101_0000 : RST1;
         checks++; if (lrclk_clear !== 1'b1 || locked !== 1'b0 || req_if.done !== 2'b00) begin errors++; $display("FAIL full_seq[T+%0d]: got clr %b lock %b done %b expected 1 0 00", k, lrclk_clear, locked, req_if.done); end
         checks++; if (cmd_reg1 !== exp1) begin errors++; $display("FAIL full_cmd1[T+%0d]: got %h expected %h", k, cmd_reg1, exp1); end
         step();
      end
      checks++; if ({req_if.done, lrclk_clear, locked} !== 4'b0101) begin errors++; $display("FAIL full_done: got done/clr/lock %b expected 0101", {req_if.done, lrclk_clear, locked}); end
      checks++; if (cmd_reg2 !== 32'h0000_0707) begin errors++; $display("FAIL full_cmd2: got %h expected 00000707", cmd_reg2); end
      step();
      checks++; if ({req_if.done, busy} !== 3'b000) begin errors++; $display("FAIL full_idle: got done/busy %b expected 000", {req_if.done, busy}); end
   endtask

   task automatic test_round_robin();
      int n;
      reset_n = 1'b0;
      req_if.req_valid = 2'b00;
      step();
      reset_n = 1'b1;
      for (int i = 0; i < SET + 1; i++) step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got busy %b expected 0", busy); end
      req_if.req0_cmd1 = 32'h0202_0000; req_if.req0_cmd2 = 32'h0000_0202;
      req_if.req1_cmd1 = 32'h0404_0000; req_if.req1_cmd2 = 32'h0000_0404;
      req_if.req_valid = 2'b11;
      #1;
      checks++; if (req_if.req_ready !== 2'b01) begin errors++; $display("FAIL rr_first: got %b expected 01", req_if.req_ready); end
      step();
      req_if.req_valid = 2'b10;
      n = 1;
      while (req_if.done === 2'b00 && n < 40) begin step(); n++; end
      checks++; if (req_if.done !== 2'b01 || n != 14) begin errors++; $display("FAIL rr_done0: got done %b at T+%0d expected 01 at T+14", req_if.done, n); end
      req_if.req_valid = 2'b11;
      #1;
      checks++; if (req_if.req_ready !== 2'b00) begin errors++; $display("FAIL rr_release_ready: got %b expected 00", req_if.req_ready); end
      step();
      checks++; if (req_if.req_ready !== 2'b10) begin errors++; $display("FAIL rr_second: got %b expected 10", req_if.req_ready); end
      step();
      req_if.req_valid = 2'b01;
      n = 1;
      while (req_if.done === 2'b00 && n < 40) begin step(); n++; end
      checks++; if (req_if.done !== 2'b10 || n != 14) begin errors++; $display("FAIL rr_done1: got done %b at T+%0d expected 10 at T+14", req_if.done, n); end
      checks++; if (cmd_reg1 !== 32'h0404_0000) begin errors++; $display("FAIL rr_cmd1: got %h expected 04040000", cmd_reg1); end
      req_if.req_valid = 2'b00;
      step();
      checks++; if ({req_if.req_ready, busy} !== 3'b000) begin errors++; $display("FAIL rr_end: got ready/busy %b expected 000", {req_if.req_ready, busy}); end
   endtask

   task automatic test_skip();
      req_if.req_valid = 2'b10;
      #1;
      checks++; if (req_if.req_ready !== 2'b10) begin errors++; $display("FAIL skip_ready: got %b expected 10", req_if.req_ready); end
      step();
      req_if.req_valid = 2'b00;
      checks++; if ({req_if.done, lrclk_clear, locked, busy} !== 5'b10011) begin errors++; $display("FAIL skip_done: got done/clr/lock/busy %b expected 10011", {req_if.done, lrclk_clear, locked, busy}); end
      checks++; if (cmd_reg1 !== 32'h0404_0000 || cmd_reg2 !== 32'h0000_0404) begin errors++; $display("FAIL skip_cmd: got %h %h expected 04040000 00000404", cmd_reg1, cmd_reg2); end
      step();
      checks++; if ({req_if.done, lrclk_clear, locked, busy} !== 5'b00010) begin errors++; $display("FAIL skip_idle: got done/clr/lock/busy %b expected 00010", {req_if.done, lrclk_clear, locked, busy}); end
   endtask

   task automatic test_hold_during_settle();
      req_if.req0_cmd1 = 32'h0505_0000;
      req_if.req0_cmd2 = 32'h0000_0505;
      req_if.req_valid = 2'b01;
      #1;
      checks++; if (req_if.req_ready !== 2'b01) begin errors++; $display("FAIL hold_ready: got %b expected 01", req_if.req_ready); end
      step();
      req_if.req_valid = 2'b11;
      for (int k = 1; k <= CLR + 1 + SET; k++) begin
         if (k == 7) req_if.req0_cmd1 = 32'h0606_0000;
         #1;
         checks++; if (req_if.req_ready !== 2'b00) begin errors++; $display("FAIL hold_busy_ready[T+%0d]: got %b expected 00", k, req_if.req_ready); end
         step();
      end
      checks++; if (req_if.done !== 2'b01 || cmd_reg1 !== 32'h0505_0000) begin errors++; $display("FAIL hold_done: got done %b cmd1 %h expected 01 05050000", req_if.done, cmd_reg1); end
      req_if.req_valid = 2'b00;
      step();
      checks++; if (cmd_reg1 !== 32'h0505_0000 || busy !== 1'b0) begin errors++; $display("FAIL hold_end: got cmd1 %h busy %b expected 05050000 0", cmd_reg1, busy); end
   endtask

   task automatic test_reset_mid_settle();
      req_if.req1_cmd1 = 32'h0707_0000;
      req_if.req1_cmd2 = 32'h0000_0101;
      req_if.req_valid = 2'b10;
      #1;
      checks++; if (req_if.req_ready !== 2'b10) begin errors++; $display("FAIL mid_ready: got %b expected 10", req_if.req_ready); end
      step();
      req_if.req_valid = 2'b00;
      for (int i = 0; i < 8; i++) step();
      checks++; if (cmd_reg1 !== 32'h0707_0000 || lrclk_clear !== 1'b1) begin errors++; $display("FAIL mid_loaded: got cmd1 %h clr %b expected 07070000 1", cmd_reg1, lrclk_clear); end
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      checks++; if (cmd_reg1 !== RST1 || cmd_reg2 !== RST2) begin errors++; $display("FAIL mid_rst_cmd: got %h %h expected %h %h", cmd_reg1, cmd_reg2, RST1, RST2); end
      checks++; if ({lrclk_clear, locked, busy} !== 3'b101) begin errors++; $display("FAIL mid_rst_status: got clr/lock/busy %b expected 101", {lrclk_clear, locked, busy}); end
      for (int i = 0; i < SET; i++) begin
         checks++; if (lrclk_clear !== 1'b1 || req_if.done !== 2'b00) begin errors++; $display("FAIL mid_settle[%0d]: got clr %b done %b expected 1 00", i, lrclk_clear, req_if.done); end
         step();
      end
      checks++; if ({lrclk_clear, locked, req_if.done} !== 4'b0100) begin errors++; $display("FAIL mid_release: got clr/lock/done %b expected 0100", {lrclk_clear, locked, req_if.done}); end
      step();
      checks++; if (busy !== 1'b0 || req_if.done !== 2'b00) begin errors++; $display("FAIL mid_idle: got busy %b done %b expected 0 00", busy, req_if.done); end
   endtask

   initial begin
      test_reset();
      test_full_path();
      test_round_robin();
      test_skip();
      test_hold_during_settle();
      test_reset_mid_settle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/audio_clk_cfg_sequencer.md
Name: audio_clk_cfg_sequencer

Overview:
Controller that owns the audio_clock_generator configuration words (cmd_reg1, cmd_reg2) and its lrclk_clear input.
- Two requesters share the clock generator: host register bridge on port 0, synth engine on port 1. Arbitration is round-robin.
- Each accepted rate change runs a glitch-safe sequence: mute LR clocks, load new divisors, let MCLK/BCLK settle, release, signal completion.
- Sits directly between the requesters and audio_clock_generator.

Parameters:
CLEAR_CYCLES, 16, cycles lrclk_clear is held before new divisors load (min 1).
SETTLE_CYCLES, 256, cycles lrclk_clear is held after the load (min 1).
RESET_CMD1, 32'h0301_0000, cmd_reg1 value after reset.
RESET_CMD2, 32'h0000_0F0F, cmd_reg2 value after reset.

Ports:
clk_clkin  in  1  single clock.
reset_n  in  1  reset, synchronous, active-low.
req_valid  in  2  per-requester request; held with data until ready.
req_ready  out  2  one-hot acceptance; transfer when valid&ready.
req0_cmd1  in  32  requester 0 cmd_reg1 word.
req0_cmd2  in  32  requester 0 cmd_reg2 word.
req1_cmd1  in  32  requester 1 cmd_reg1 word.
req1_cmd2  in  32  requester 1 cmd_reg2 word.
done  out  2  one-cycle completion pulse to the granted requester.
cmd_reg1  out  32  to clock generator.
cmd_reg2  out  32  to clock generator.
lrclk_clear  out  1  to clock generator; holds LR dividers in reset.
busy  out  1  high in any state other than IDLE.
locked  out  1  clocks stable at the current configuration.

Behaviour:
- Reset (reset_n low at a rising edge):
  - state=SETTLE, counter=0.
  - cmd_reg1=RESET_CMD1, cmd_reg2=RESET_CMD2.
  - lrclk_clear=1, locked=0, busy=1, req_ready=0, done=0.
  - Last-grant pointer=1, so requester 0 wins first.
  - The staged request and any pending done are discarded.
- States: IDLE, CLEAR, LOAD, SETTLE, RELEASE.
- IDLE:
  - req_ready is combinational from the arbiter, one-hot, and only in IDLE.
  - If one requester is valid, it gets ready.
  - If both are valid, the requester not granted last gets ready.
  - On transfer, stage cmd1/cmd2 and the grant id, then update the last-grant pointer.
  - If the staged words equal cmd_reg1/cmd_reg2 and locked=1, go to RELEASE (skip path, lrclk_clear never asserts).
  - Otherwise go to CLEAR, and locked drops to 0 the next cycle.
- CLEAR: lrclk_clear=1 for CLEAR_CYCLES cycles, then LOAD.
- LOAD:
  - One cycle, lrclk_clear=1.
  - cmd_reg1/cmd_reg2 take the staged words, visible the following cycle.
  - Then SETTLE.
- SETTLE: lrclk_clear=1 for SETTLE_CYCLES cycles, then RELEASE.
- RELEASE:
  - One cycle, lrclk_clear=0.
  - done[grant]=1 (no done after the power-on settle).
  - locked=1 from this cycle.
  - Then IDLE.
- Timing, handshake at cycle T, full path:
  - lrclk_clear high T+1 through T+1+CLEAR_CYCLES+SETTLE_CYCLES, i.e. CLEAR_CYCLES+1+SETTLE_CYCLES cycles.
  - cmd_reg* change at T+2+CLEAR_CYCLES.
  - done at T+2+CLEAR_CYCLES+SETTLE_CYCLES.
- Timing, skip path: done at T+1.
- A new request is accepted no earlier than the cycle after RELEASE.
- Counter is sized clog2(max(CLEAR_CYCLES,SETTLE_CYCLES)+1) and is reloaded on each state entry.
- cmd inputs are sampled only at the handshake; later changes have no effect.
- A requester dropping valid before ready: no transfer, no pointer update.
- Reset mid-sequence: cmd regs return to their RESET_* values and the power-on settle repeats.
- Word field layout is owned by the clock generator: cmd1[31:24] mclk, cmd1[23:16] bclk, cmd2[15:8] lrclk1, cmd2[7:0] lrclk2. This block passes words through unmodified.

Decomposition:
- Package audio_clk_pkg holds:
  - state enum.
  - field MSB/LSB constants for the four divisor fields.
  - RESET_CMD defaults.
- One sub-module, audio_clk_rr_arbiter: 2-way round-robin arbiter.
  - Inputs: req[1:0], enable, advance.
  - Outputs: gnt[1:0] one-hot, gnt_id.
  - Pointer updates on advance.

Test Plan:
1. Reset, CLEAR=4, SETTLE=8 -> lrclk_clear=1 for exactly 8 cycles after reset release, then 0; locked=1; no done; cmd_reg1=32'h0301_0000, cmd_reg2=32'h0000_0F0F.
2. req0 valid, cmd1=32'h0101_0000, cmd2=32'h0000_0707, handshake at T -> lrclk_clear high T+1..T+13; cmd_reg1=32'h0101_0000 from T+6; done[0] pulses at T+14; locked low T+1..T+13.
3. Both valid in the same cycle after reset -> ready[0] first. After done[0], with req1 still valid, ready[1] is granted even if req0 reasserts.
4. req1 requests the current words while locked -> done[1] at T+1; lrclk_clear stays 0; locked stays 1; cmd regs unchanged.
5. req0 changes cmd1 data while SETTLE is in progress -> cmd_reg1 keeps the staged value; req_ready stays 0 for both ports until IDLE.
6. reset_n low during SETTLE of a req1 sequence -> cmd regs back to RESET_* next cycle; no done[1]; power-on 8-cycle settle repeats.
